// File: rtl/i2c_multi_byte_sequencer.sv
// rtl/i2c_multi_byte_sequencer.sv - I2C master phase sequencer: burst write, repeated-START register read, address probe
// Drives SCL/SDA control levels and hands each byte to the external shifter, checking slave ACKs.
module i2c_multi_byte_sequencer #(
    parameter  int MAX_BYTES         = 16,
    parameter  int START_STOP_DELAY  = 350,
    parameter  int SCL_RISE_DELAY    = 157,
    parameter  int ACK_DELAY         = 1600,
    parameter  int SDA_RELEASE_DELAY = 540,
    parameter  int BUS_FREE_DELAY    = 300,
    localparam int NW                = $clog2(MAX_BYTES + 1),
    localparam int IW                = $clog2(MAX_BYTES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_transfer,
    input  logic          read_mode,
    input  logic [NW-1:0] n_bytes,
    input  logic          byte_done,
    input  logic          ack,
    output logic          shift_byte,
    output logic [1:0]    byte_kind,
    output logic [IW-1:0] byte_index,
    output logic          master_ack,
    output logic          timebase_enable,
    output logic          sda_control,
    output logic          scl_control,
    output logic          busy,
    output logic          transfer_done,
    output logic          nack_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_BYTE,
        S_ACK_WAIT,
        S_RSTART,
        S_STOP,
        S_BUS_FREE
    } state_t;

    localparam logic [1:0] KIND_ADDR_W  = 2'd0;
    localparam logic [1:0] KIND_ADDR_R  = 2'd1;
    localparam logic [1:0] KIND_WR_DATA = 2'd2;
    localparam logic [1:0] KIND_RD_DATA = 2'd3;

    localparam logic [15:0] T_START_STOP  = 16'(START_STOP_DELAY);
    localparam logic [15:0] T_SCL_RISE    = 16'(SCL_RISE_DELAY);
    localparam logic [15:0] T_ACK         = 16'(ACK_DELAY);
    localparam logic [15:0] T_SDA_RELEASE = 16'(SDA_RELEASE_DELAY);
    localparam logic [15:0] T_BUS_FREE    = 16'(BUS_FREE_DELAY);
    localparam logic [15:0] T_RS_SDA      = 16'(2 * SCL_RISE_DELAY);
    localparam logic [15:0] T_RS_END      = 16'(2 * SCL_RISE_DELAY + START_STOP_DELAY);
    localparam logic [NW-1:0] MAX_N       = NW'(MAX_BYTES);

    state_t          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic [NW-1:0]   n_bytes_q, n_bytes_d;
    logic            read_mode_q, read_mode_d;
    logic            nack_error_q, nack_error_d;
    logic            sda_q, sda_d;
    logic            scl_q, scl_d;
    logic            tb_en_q, tb_en_d;
    logic            busy_q, busy_d;
    logic [1:0]      kind_q, kind_d;
    logic [IW-1:0]   index_q, index_d;
    logic            done_q, done_d;
    logic [NW-1:0]   index_ext;
    logic            last_data;

    assign index_ext = NW'(index_q);
    assign last_data = (index_ext + NW'(1)) == n_bytes_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            n_bytes_q    <= '0;
            read_mode_q  <= 1'b0;
            nack_error_q <= 1'b0;
            sda_q        <= 1'b1;
            scl_q        <= 1'b1;
            tb_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            kind_q       <= KIND_ADDR_W;
            index_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            n_bytes_q    <= n_bytes_d;
            read_mode_q  <= read_mode_d;
            nack_error_q <= nack_error_d;
            sda_q        <= sda_d;
            scl_q        <= scl_d;
            tb_en_q      <= tb_en_d;
            busy_q       <= busy_d;
            kind_q       <= kind_d;
            index_q      <= index_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_bytes_d    = n_bytes_q;
        read_mode_d  = read_mode_q;
        nack_error_d = nack_error_q;
        sda_d        = sda_q;
        scl_d        = scl_q;
        tb_en_d      = tb_en_q;
        busy_d       = busy_q;
        kind_d       = kind_q;
        index_d      = index_q;
        done_d       = 1'b0;
        timer_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (start_transfer) begin
                    // Counts beyond MAX_BYTES would overflow byte_index, so clamp them.
                    n_bytes_d    = (n_bytes > MAX_N) ? MAX_N : n_bytes;
                    read_mode_d  = read_mode;
                    nack_error_d = 1'b0;
                    sda_d        = 1'b0;
                    busy_d       = 1'b1;
                    index_d      = '0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (timer_q == T_START_STOP) begin
                    scl_d   = 1'b0;
                    tb_en_d = 1'b1;
                    kind_d  = KIND_ADDR_W;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_BYTE: begin
                // A done strobe coinciding with our own shift_byte belongs to the previous byte.
                if (byte_done && timer_q != '0) begin
                    state_d = S_ACK_WAIT;
                end
            end
            S_ACK_WAIT: begin
                if (timer_q > T_SDA_RELEASE) begin
                    sda_d = 1'b1;
                end
                if (timer_q == T_ACK) begin
                    if (kind_q == KIND_WR_DATA || kind_q == KIND_RD_DATA) begin
                        index_d = index_q + IW'(1);
                    end
                    if (kind_q != KIND_RD_DATA && !ack) begin
                        nack_error_d = 1'b1;
                        state_d      = S_STOP;
                    end else begin
                        case (kind_q)
                            KIND_ADDR_W: begin
                                if (n_bytes_q == '0) begin
                                    state_d = S_STOP;
                                end else begin
                                    kind_d  = KIND_WR_DATA;
                                    state_d = S_BYTE;
                                end
                            end
                            KIND_WR_DATA: begin
                                if (read_mode_q) begin
                                    index_d = '0;
                                    state_d = S_RSTART;
                                end else begin
                                    state_d = last_data ? S_STOP : S_BYTE;
                                end
                            end
                            KIND_ADDR_R: begin
                                kind_d  = KIND_RD_DATA;
                                state_d = S_BYTE;
                            end
                            default: begin
                                state_d = last_data ? S_STOP : S_BYTE;
                            end
                        endcase
                    end
                    if (state_d == S_STOP || state_d == S_BYTE) begin
                        sda_d = 1'b0;
                    end
                end
            end
            S_RSTART: begin
                if (timer_q == T_SCL_RISE) begin
                    scl_d = 1'b1;
                end
                if (timer_q == T_RS_SDA) begin
                    sda_d = 1'b0;
                end
                if (timer_q == T_RS_END) begin
                    scl_d   = 1'b0;
                    kind_d  = KIND_ADDR_R;
                    state_d = S_ADDR;
                end
            end
            S_STOP: begin
                if (timer_q == T_SCL_RISE) begin
                    scl_d = 1'b1;
                end
                if (timer_q == T_START_STOP) begin
                    sda_d   = 1'b1;
                    tb_en_d = 1'b0;
                    state_d = S_BUS_FREE;
                end
            end
            S_BUS_FREE: begin
                if (timer_q == T_BUS_FREE) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturate so a stalled shifter can never wrap back to timer 0 and re-pulse shift_byte.
        if (state_d == state_q && state_q != S_IDLE && timer_q != 16'hFFFF) begin
            timer_d = timer_q + 16'd1;
        end
    end

    assign shift_byte      = (state_q == S_ADDR || state_q == S_BYTE) && timer_q == '0;
    assign byte_kind       = kind_q;
    assign byte_index      = index_q;
    assign master_ack      = (kind_q == KIND_RD_DATA) && !last_data;
    assign timebase_enable = tb_en_q;
    assign sda_control     = sda_q;
    assign scl_control     = scl_q;
    assign busy            = busy_q;
    assign transfer_done   = done_q;
    assign nack_error      = nack_error_q;

endmodule

// File: tb/tb_i2c_multi_byte_sequencer.sv
// tb/tb_i2c_multi_byte_sequencer.sv - randomized self-checking bench against a byte-sequence reference model
module tb_i2c_multi_byte_sequencer;

    localparam int SS = 10, SR = 4, ACKD = 20, SDR = 12, BF = 8, MAXB = 16;
    localparam int BYTE_T = 19;
    localparam int ACK_T = ACKD + 1;
    localparam int START_T = SS + 1, STOP_T = SS + 1, FREE_T = BF + 1;
    localparam int RST_T = 2 * SR + SS + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_transfer = 1'b0;
    logic       read_mode = 1'b0;
    logic [4:0] n_bytes = '0;
    logic       byte_done = 1'b0;
    logic       ack = 1'b1;
    logic       shift_byte, master_ack, timebase_enable, sda_control, scl_control;
    logic       busy, transfer_done, nack_error;
    logic [1:0] byte_kind;
    logic [3:0] byte_index;

    i2c_multi_byte_sequencer #(
        .MAX_BYTES(MAXB), .START_STOP_DELAY(SS), .SCL_RISE_DELAY(SR),
        .ACK_DELAY(ACKD), .SDA_RELEASE_DELAY(SDR), .BUS_FREE_DELAY(BF)
    ) dut (
        .clock(clock), .reset(reset), .start_transfer(start_transfer),
        .read_mode(read_mode), .n_bytes(n_bytes), .byte_done(byte_done), .ack(ack),
        .shift_byte(shift_byte), .byte_kind(byte_kind), .byte_index(byte_index),
        .master_ack(master_ack), .timebase_enable(timebase_enable),
        .sda_control(sda_control), .scl_control(scl_control), .busy(busy),
        .transfer_done(transfer_done), .nack_error(nack_error)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    // shifter model and bus monitor
    int cyc = 0, bd_cnt = 0, shift_ord = 0, done_cnt = 0;
    int fall_hi = 0, rise_hi = 0, busy_rise_cyc = 0, done_cyc = 0, scl_gap = -1;
    int nack_abs = -1;
    bit stray = 0;
    bit prev_sda = 1, prev_scl = 1, prev_busy = 0, scl_armed = 0;
    logic [6:0] obs_q[$];

    always @(negedge clock) begin
        cyc++;
        byte_done = 1'b0;
        if (!reset) begin
            bd_cnt = 0;
        end else if (shift_byte) begin
            obs_q.push_back({byte_kind, byte_index, master_ack});
            ack = (shift_ord != nack_abs);
            shift_ord++;
            bd_cnt = 18;
            if (stray) byte_done = 1'b1;
        end else if (bd_cnt > 0) begin
            bd_cnt--;
            if (bd_cnt == 0) byte_done = 1'b1;
        end
        if (prev_sda && !sda_control && scl_control) fall_hi++;
        if (!prev_sda && sda_control && scl_control) rise_hi++;
        if (busy && !prev_busy) begin
            busy_rise_cyc = cyc;
            scl_armed = 1;
        end
        if (prev_scl && !scl_control && scl_armed) begin
            scl_gap = cyc - busy_rise_cyc;
            scl_armed = 0;
        end
        if (transfer_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_sda = sda_control;
        prev_scl = scl_control;
        prev_busy = busy;
    end

    // reference model: expected byte list, abort and total duration from the transfer rules
    logic [6:0] exp_q[$];
    int exp_dur;
    bit exp_nack, exp_rstart;

    function automatic logic [6:0] pack(input int k, input int i, input bit m);
        logic [1:0] kk;
        logic [3:0] ii;
        kk = k[1:0];
        ii = i[3:0];
        return {kk, ii, m};
    endfunction

    function automatic void model(input bit rm, input int n, input int nack_at);
        exp_q.delete();
        exp_nack = 0;
        exp_rstart = 0;
        exp_q.push_back(pack(0, 0, 0));
        if (nack_at == 0) begin
            exp_nack = 1;
        end else if (n > 0) begin
            if (!rm) begin
                for (int i = 0; i < n && !exp_nack; i++) begin
                    exp_q.push_back(pack(2, i, 0));
                    if (nack_at == exp_q.size() - 1) exp_nack = 1;
                end
            end else begin
                exp_q.push_back(pack(2, 0, 0));
                if (nack_at == 1) begin
                    exp_nack = 1;
                end else begin
                    exp_rstart = 1;
                    exp_q.push_back(pack(1, 0, 0));
                    if (nack_at == 2) exp_nack = 1;
                    else for (int i = 0; i < n; i++) exp_q.push_back(pack(3, i, i != n - 1));
                end
            end
        end
        exp_dur = START_T + exp_q.size() * (BYTE_T + ACK_T) + (exp_rstart ? RST_T : 0) + STOP_T + FREE_T;
    endfunction

    int base_obs, base_done, base_fall, base_rise;

    task automatic run_xfer(input bit rm, input int n, input int nack_at, input bit str, input bit mid);
        bit got;
        base_obs = obs_q.size();
        base_done = done_cnt;
        base_fall = fall_hi;
        base_rise = rise_hi;
        nack_abs = (nack_at < 0) ? -1 : shift_ord + nack_at;
        stray = str;
        read_mode = rm;
        n_bytes = 5'(n);
        start_transfer = 1'b1;
        @(negedge clock); #1;
        start_transfer = 1'b0;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clock); #1;
            if (mid && i == 60) start_transfer = 1'b1;
            if (mid && i == 61) start_transfer = 1'b0;
            if (done_cnt != base_done) got = 1;
        end
        start_transfer = 1'b0;
        repeat (20) @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({sda_control, scl_control} !== 2'b11) begin
            errors++; $display("FAIL reset_bus got %b want 11", {sda_control, scl_control});
        end
        checks++;
        if ({shift_byte, byte_kind, byte_index, master_ack, timebase_enable, busy, transfer_done, nack_error} !== '0) begin
            errors++; $display("FAIL reset_outs got %b want 0",
                {shift_byte, byte_kind, byte_index, master_ack, timebase_enable, busy, transfer_done, nack_error});
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_write_burst;
        for (int t = 0; t < 4; t++) begin
            int n = (t == 0) ? 3 : int'($urandom_range(6, 1));
            bit str = (t == 0) ? 1'b0 : 1'($urandom_range(1, 0));
            model(0, n, -1);
            run_xfer(0, n, -1, str, 0);
            checks++;
            if (obs_q.size() - base_obs != exp_q.size()) begin
                errors++; $display("FAIL wr_len n=%0d got %0d want %0d", n, obs_q.size() - base_obs, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base_obs + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[base_obs + i] !== exp_q[i]) begin
                    errors++; $display("FAIL wr_seq[%0d] got %h want %h", i, obs_q[base_obs + i], exp_q[i]);
                end
            end
            checks++;
            if (done_cyc - busy_rise_cyc != exp_dur) begin
                errors++; $display("FAIL wr_dur got %0d want %0d", done_cyc - busy_rise_cyc, exp_dur);
            end
            checks++;
            if (done_cnt - base_done != 1) begin errors++; $display("FAIL wr_done got %0d want 1", done_cnt - base_done); end
            checks++;
            if (nack_error !== 1'b0) begin errors++; $display("FAIL wr_nack got %b want 0", nack_error); end
            checks++;
            if (scl_gap != START_T) begin errors++; $display("FAIL wr_start_gap got %0d want %0d", scl_gap, START_T); end
            checks++;
            if (fall_hi - base_fall != 1 || rise_hi - base_rise != 1) begin
                errors++; $display("FAIL wr_start_stop got %0d/%0d want 1/1", fall_hi - base_fall, rise_hi - base_rise);
            end
        end
    endtask

    task automatic test_read;
        for (int t = 0; t < 3; t++) begin
            int n = (t == 0) ? 2 : int'($urandom_range(5, 1));
            int na = (t == 0) ? -1 : int'($urandom_range(n + 2, 3));
            model(1, n, na);
            run_xfer(1, n, na, 0, 0);
            checks++;
            if (obs_q.size() - base_obs != exp_q.size()) begin
                errors++; $display("FAIL rd_len n=%0d got %0d want %0d", n, obs_q.size() - base_obs, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base_obs + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[base_obs + i] !== exp_q[i]) begin
                    errors++; $display("FAIL rd_seq[%0d] got %h want %h", i, obs_q[base_obs + i], exp_q[i]);
                end
            end
            checks++;
            if (done_cyc - busy_rise_cyc != exp_dur) begin
                errors++; $display("FAIL rd_dur got %0d want %0d", done_cyc - busy_rise_cyc, exp_dur);
            end
            checks++;
            if (fall_hi - base_fall != 2 || rise_hi - base_rise != 1) begin
                errors++; $display("FAIL rd_rstart_edges got %0d/%0d want 2/1", fall_hi - base_fall, rise_hi - base_rise);
            end
            checks++;
            if (nack_error !== 1'b0 || done_cnt - base_done != 1) begin
                errors++; $display("FAIL rd_end nack=%b done=%0d want 0/1", nack_error, done_cnt - base_done);
            end
        end
    endtask

    task automatic test_nack;
        for (int t = 0; t < 4; t++) begin
            bit rm = (t == 0) ? 1'b0 : 1'($urandom_range(1, 0));
            int n = (t == 0) ? 4 : int'($urandom_range(5, 1));
            int na = (t == 0) ? 2 : int'($urandom_range(rm ? 2 : n, 0));
            model(rm, n, na);
            run_xfer(rm, n, na, 0, 0);
            checks++;
            if (obs_q.size() - base_obs != exp_q.size()) begin
                errors++; $display("FAIL nk_len got %0d want %0d", obs_q.size() - base_obs, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base_obs + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[base_obs + i] !== exp_q[i]) begin
                    errors++; $display("FAIL nk_seq[%0d] got %h want %h", i, obs_q[base_obs + i], exp_q[i]);
                end
            end
            checks++;
            if (nack_error !== exp_nack) begin errors++; $display("FAIL nk_flag got %b want %b", nack_error, exp_nack); end
            checks++;
            if (done_cnt - base_done != 1) begin errors++; $display("FAIL nk_done got %0d want 1", done_cnt - base_done); end
            checks++;
            if (done_cyc - busy_rise_cyc != exp_dur) begin
                errors++; $display("FAIL nk_dur got %0d want %0d", done_cyc - busy_rise_cyc, exp_dur);
            end
        end
        run_xfer(0, 1, -1, 0, 0);
        checks++;
        if (nack_error !== 1'b0) begin errors++; $display("FAIL nk_clear got %b want 0", nack_error); end
    endtask

    task automatic test_probe;
        for (int rm = 0; rm < 2; rm++) begin
            model(1'(rm), 0, -1);
            run_xfer(1'(rm), 0, -1, 0, 0);
            checks++;
            if (obs_q.size() - base_obs != 1 || obs_q[obs_q.size() - 1] !== exp_q[0]) begin
                errors++; $display("FAIL pr_seq got %0d bytes last %h want 1 byte %h", obs_q.size() - base_obs, obs_q[obs_q.size() - 1], exp_q[0]);
            end
            checks++;
            if (done_cyc - busy_rise_cyc != exp_dur) begin
                errors++; $display("FAIL pr_dur got %0d want %0d", done_cyc - busy_rise_cyc, exp_dur);
            end
            checks++;
            if ({sda_control, scl_control, timebase_enable, busy} !== 4'b1100 || done_cnt - base_done != 1) begin
                errors++; $display("FAIL pr_release got %b done %0d want 1100 done 1",
                    {sda_control, scl_control, timebase_enable, busy}, done_cnt - base_done);
            end
        end
    endtask

    task automatic test_max_bytes;
        for (int rm = 0; rm < 2; rm++) begin
            model(1'(rm), MAXB, -1);
            run_xfer(1'(rm), MAXB, -1, 0, 0);
            checks++;
            if (obs_q.size() - base_obs != exp_q.size()) begin
                errors++; $display("FAIL mx_len got %0d want %0d", obs_q.size() - base_obs, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base_obs + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[base_obs + i] !== exp_q[i]) begin
                    errors++; $display("FAIL mx_seq[%0d] got %h want %h", i, obs_q[base_obs + i], exp_q[i]);
                end
            end
            checks++;
            if (done_cyc - busy_rise_cyc != exp_dur) begin
                errors++; $display("FAIL mx_dur got %0d want %0d", done_cyc - busy_rise_cyc, exp_dur);
            end
        end
    endtask

    task automatic test_midstart_ignored;
        model(0, 3, -1);
        run_xfer(0, 3, -1, 0, 1);
        checks++;
        if (done_cnt - base_done != 1) begin errors++; $display("FAIL ms_done got %0d want 1", done_cnt - base_done); end
        checks++;
        if (obs_q.size() - base_obs != exp_q.size() || busy !== 1'b0) begin
            errors++; $display("FAIL ms_extra bytes %0d busy %b want %0d/0", obs_q.size() - base_obs, busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_transfer;
        bit got = 0;
        int b = obs_q.size();
        int d0;
        nack_abs = -1;
        stray = 0;
        read_mode = 1'b0;
        n_bytes = 5'd4;
        start_transfer = 1'b1;
        @(negedge clock); #1;
        start_transfer = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clock); #1;
            if (obs_q.size() > b && obs_q[obs_q.size() - 1][6:5] == 2'd2) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rm_reach got 0 want 1"); end
        reset = 1'b0;
        @(negedge clock); #1;
        checks++;
        if ({sda_control, scl_control, busy, timebase_enable} !== 4'b1100) begin
            errors++; $display("FAIL rm_release got %b want 1100", {sda_control, scl_control, busy, timebase_enable});
        end
        @(negedge clock); #1;
        reset = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clock);
        #1;
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_quiet done %0d busy %b want 0/0", done_cnt - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read();
        test_nack();
        test_probe();
        test_max_bytes();
        test_midstart_ignored();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_multi_byte_sequencer.md
Name: i2c_multi_byte_sequencer

Overview:
- Next-generation I2C master transfer sequencer.
- Generalises the fixed address/register/data write sequence to N-byte burst writes, register reads with repeated START, and address-only probes.
- Adds real ACK checking with NACK abort.
- Drives SCL/SDA control lines and handshakes per byte with the existing byte shifter and timebase inside the I2C component.

Parameters:
- MAX_BYTES, 16, maximum bytes per transfer after the address; n_bytes width is $clog2(MAX_BYTES+1).
- START_STOP_DELAY, 350, clocks SDA is held low before SCL falls (START/RSTART), and before SDA rises (STOP).
- SCL_RISE_DELAY, 157, clock count within STOP/RSTART at which SCL is released high.
- ACK_DELAY, 1600, length of the ACK window in clocks; ACK is sampled at its last clock.
- SDA_RELEASE_DELAY, 540, clock count within the ACK window after which SDA is released high.
- BUS_FREE_DELAY, 300, clocks of idle bus after STOP before done.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous, active-low.
- start_transfer, input, 1, level request; sampled only in IDLE.
- read_mode, input, 1, 0 = burst write; 1 = write one register byte, then RSTART and read.
- n_bytes, input, $clog2(MAX_BYTES+1), byte count; latched at start.
- byte_done, input, 1, shifter finished current byte (1-cycle pulse).
- ack, input, 1, 1 = slave ACK seen by shifter in the ACK window.
- shift_byte, output, 1, 1-cycle pulse: shifter begins a byte.
- byte_kind, output, 2, 0 = addr+W, 1 = addr+R, 2 = write data, 3 = read data.
- byte_index, output, $clog2(MAX_BYTES), index of the current data byte.
- master_ack, output, 1, for read bytes: 1 = drive ACK, 0 = NACK (last byte).
- timebase_enable, output, 1, SCL timebase run enable.
- sda_control, output, 1, SDA drive (0 = pull low).
- scl_control, output, 1, SCL drive (0 = pull low).
- busy, output, 1, high from START entry until done.
- transfer_done, output, 1, 1-cycle pulse at end of transfer.
- nack_error, output, 1, set on NACK abort; cleared on next start.

Behaviour:
- Reset values: sda/scl = 1; all other outputs 0; state = IDLE; timer = 0. Reset mid-transfer releases the bus on the next edge, with no STOP sequence.
- A 16-bit wait timer clears on every state entry and increments while in timed states. "Timer == D" means the state lasts D+1 clocks.
- IDLE:
  - On start_transfer: latch n_bytes and read_mode; clear nack_error; sda = 0; busy = 1; go to START.
  - start_transfer while busy is ignored.
- START:
  - At timer == START_STOP_DELAY: scl = 0, timebase_enable = 1, go to ADDR with byte_kind = 0.
- ADDR / BYTE:
  - Pulse shift_byte on the first cycle in the state; sda = 0 is owned by the shifter path.
  - On byte_done: go to ACK_WAIT.
  - byte_done in the same cycle as the shift_byte pulse is ignored.
- ACK_WAIT (after addr or write byte):
  - At timer > SDA_RELEASE_DELAY: sda = 1.
  - At timer == ACK_DELAY, if ack = 0: set nack_error, go to STOP.
  - At timer == ACK_DELAY, otherwise advance:
    - write: next write byte while index < n_bytes-1, else STOP;
    - read after register byte: RSTART;
    - after addr+R: first read byte.
  - n_bytes = 0 (either mode): address-only probe; after the addr+W ACK go to STOP.
- Read bytes (byte_kind = 3):
  - master_ack = 1 except for the byte with index n_bytes-1, where it is 0.
  - The ACK window is timed but ack is not checked.
  - After the last read byte, go to STOP.
- Read mode with n_bytes = 1: register byte index 0, then one read byte.
- byte_index:
  - Resets to 0 at start; increments on leaving each data-byte ACK window.
  - Restarts at 0 for read data after RSTART.
- RSTART:
  - sda = 1; scl = 1 at timer == SCL_RISE_DELAY.
  - At 2*SCL_RISE_DELAY: sda = 0.
  - At 2*SCL_RISE_DELAY + START_STOP_DELAY: scl = 0, go to ADDR with byte_kind = 1.
- STOP:
  - sda = 0; scl = 1 at timer == SCL_RISE_DELAY.
  - At START_STOP_DELAY: sda = 1, timebase_enable = 0, go to BUS_FREE.
- BUS_FREE:
  - At BUS_FREE_DELAY: pulse transfer_done, busy = 0, go to IDLE.
  - nack_error is held until the next start.

Test Plan (delays set to START_STOP=10, SCL_RISE=4, ACK=20, SDA_RELEASE=12, BUS_FREE=8; shifter model returns byte_done 18 clocks after shift_byte):
- Write, n_bytes = 3, ack always 1 -> byte_kind sequence 0, 2, 2, 2 with byte_index 0..2; exactly 4 shift_byte pulses; sda falls 11 clocks before scl at START; one transfer_done; nack_error = 0.
- Read, n_bytes = 2 -> byte_kind 0, 2 (idx 0), RSTART, 1, 3 (idx 0, master_ack = 1), 3 (idx 1, master_ack = 0); sda falls while scl = 1 in RSTART; then STOP.
- Write, n_bytes = 4, ack = 0 on the second data byte -> STOP right after that ACK window; nack_error = 1; only 3 shift_byte pulses; transfer_done pulses once.
- n_bytes = 0 with read_mode = 1 -> single addr+W byte, then STOP; bus released; transfer_done after 11+11+9 timed clocks plus the byte time.
- reset asserted during a data byte -> next edge: sda = scl = 1, busy = 0, timebase_enable = 0. start_transfer pulsed mid-transfer -> ignored, no second transfer.
